// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer.
// Drives the panel hardware reset low and then high through the reset block.
// Then it streams a fixed command/data/delay script from an internal ROM to
// the SPI byte writer, and finally raises o_init_done.
// Optional build macro INIT_RESTART_EN adds i_restart. A pulse on it in DONE
// re-runs the whole sequence. Without the macro, DONE is terminal until reset.
module ili9341_init_seq #(
    parameter int CLK_PER_MS = 4000,
    parameter int ROM_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
`ifdef INIT_RESTART_EN
    input  logic       i_restart,
`endif
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_reset_ena,
    output logic       o_reset_val,
    input  logic       i_reset_sent,
    output logic       o_spi_start,
    output logic       o_spi_dc,
    output logic [7:0] o_spi_data,
    input  logic       i_spi_done
);

    localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    localparam logic [AW-1:0] LAST_ADDR  = AW'(ROM_DEPTH - 1);
    localparam logic [CW-1:0] CYC_RELOAD = CW'(CLK_PER_MS - 1);
    // The FETCH cycle that decodes a delay already counts as the first tick
    // of its first millisecond, so the first reload is one short.
    localparam logic [CW-1:0] CYC_FIRST  = (CLK_PER_MS > 1) ? CW'(CLK_PER_MS - 2) : '0;

    localparam logic [1:0] T_CMD = 2'b00;
    localparam logic [1:0] T_DAT = 2'b01;
    localparam logic [1:0] T_DLY = 2'b10;
    localparam logic [1:0] T_END = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_LO,
        S_RST_LO_W,
        S_RST_HI,
        S_RST_HI_W,
        S_FETCH,
        S_SEND,
        S_WAIT_TX,
        S_DELAY,
        S_DONE
    } state_e;

    // Script word layout: {type[1:0], payload[7:0]}.
    function automatic logic [9:0] rom_entry(input logic [AW-1:0] addr);
        logic [9:0] w;
        case (int'(addr))
            0:       w = {T_CMD, 8'h01};   // software reset
            1:       w = {T_DLY, 8'd5};
            2:       w = {T_CMD, 8'h11};   // sleep out
            3:       w = {T_DLY, 8'd120};
            4:       w = {T_CMD, 8'h3A};   // pixel format
            5:       w = {T_DAT, 8'h55};   // 16 bpp
            6:       w = {T_CMD, 8'h36};   // memory access control
            7:       w = {T_DAT, 8'h48};
            8:       w = {T_CMD, 8'h29};   // display on
            default: w = {T_END, 8'h00};
        endcase
        return w;
    endfunction

    state_e          state_q;
    logic [AW-1:0]   ptr_q;
    logic [7:0]      ms_q;
    logic [CW-1:0]   cyc_q;
    logic            busy_q;
    logic            done_q;
    logic            rena_q;
    logic            rval_q;
    logic            spi_start_q;
    logic            spi_dc_q;
    logic [7:0]      spi_data_q;

    logic [9:0]      rom_word;
    logic [1:0]      rom_type;
    logic [7:0]      rom_pay;
    logic            adv;

    assign rom_word = rom_entry(ptr_q);
    assign rom_type = rom_word[9:8];
    assign rom_pay  = rom_word[7:0];

    // Current script step has finished: move to the next entry (or stop at the ROM end).
    always_comb begin
        adv = 1'b0;
        case (state_q)
            S_FETCH:   adv = (rom_type == T_DLY) && (rom_pay == 8'd0);
            S_WAIT_TX: adv = i_spi_done;
            S_DELAY:   adv = (cyc_q == '0) && (ms_q == 8'd0);
            default:   adv = 1'b0;
        endcase
    end

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            ms_q        <= 8'd0;
            cyc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rena_q      <= 1'b0;
            rval_q      <= 1'b1;
            spi_start_q <= 1'b0;
            spi_dc_q    <= 1'b0;
            spi_data_q  <= 8'd0;
        end else begin
            rena_q      <= 1'b0;
            spi_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_RST_LO;
                        rena_q  <= 1'b1;
                        rval_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RST_LO: state_q <= S_RST_LO_W;
                S_RST_LO_W: begin
                    if (i_reset_sent) begin
                        state_q <= S_RST_HI;
                        rena_q  <= 1'b1;
                        rval_q  <= 1'b1;
                    end
                end
                S_RST_HI: state_q <= S_RST_HI_W;
                S_RST_HI_W: begin
                    if (i_reset_sent) begin
                        state_q <= S_FETCH;
                        ptr_q   <= '0;
                    end
                end
                S_FETCH: begin
                    case (rom_type)
                        T_CMD, T_DAT: begin
                            state_q     <= S_SEND;
                            spi_start_q <= 1'b1;
                            spi_dc_q    <= (rom_type == T_DAT);
                            spi_data_q  <= rom_pay;
                        end
                        T_DLY: begin
                            // Zero-length delays are skipped through adv.
                            if (rom_pay != 8'd0) begin
                                state_q <= S_DELAY;
                                ms_q    <= rom_pay - 8'd1;
                                cyc_q   <= CYC_FIRST;
                            end
                        end
                        default: begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    endcase
                end
                S_SEND: state_q <= S_WAIT_TX;
                S_WAIT_TX: begin
                    // dc/data stay put; completion is handled through adv.
                end
                S_DELAY: begin
                    if (cyc_q == '0) begin
                        if (ms_q != 8'd0) begin
                            ms_q  <= ms_q - 8'd1;
                            cyc_q <= CYC_RELOAD;
                        end
                    end else begin
                        cyc_q <= cyc_q - CW'(1);
                    end
                end
                S_DONE: begin
`ifdef INIT_RESTART_EN
                    if (i_restart) begin
                        state_q <= S_RST_LO;
                        rena_q  <= 1'b1;
                        rval_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase

            if (adv) begin
                if (ptr_q == LAST_ADDR) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_FETCH;
                    ptr_q   <= ptr_q + AW'(1);
                end
            end
        end
    end

    assign o_busy      = busy_q;
    assign o_init_done = done_q;
    assign o_reset_ena = rena_q;
    assign o_reset_val = rval_q;
    assign o_spi_start = spi_start_q;
    assign o_spi_dc    = spi_dc_q;
    assign o_spi_data  = spi_data_q;

endmodule

// File: doc/ili9341_init_seq.md
Name: ili9341_init_seq

Overview:
- Power-up sequencer for the ILI9341 panel.
- On start it drives the hardware-reset pulse generator through two pulses: RESX low, then RESX high.
- It then streams a fixed command/data/delay script from an internal ROM to the SPI byte transmitter.
- It sits between the top-level control FSM and the reset and SPI writer blocks. When done it raises o_init_done so pixel streaming may begin.

Parameters:
- CLK_PER_MS, 4000, clock cycles per millisecond. Delay tick base; 4 MHz clock gives 60_000 cycles per 15 ms.
- ROM_DEPTH, 16, number of script entries. Address width is $clog2(ROM_DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; begins sequence when in IDLE
- o_busy  out  1  high from leaving IDLE until entering DONE
- o_init_done  out  1  level; high while in DONE
- o_reset_ena  out  1  one-cycle request to reset block
- o_reset_val  out  1  RESX level requested; valid with o_reset_ena
- i_reset_sent  in  1  one-cycle completion pulse from reset block (after its 15 ms wait)
- o_spi_start  out  1  one-cycle byte-send request
- o_spi_dc  out  1  0 = command, 1 = data; held until i_spi_done
- o_spi_data  out  8  byte; held until i_spi_done
- i_spi_done  in  1  one-cycle byte-complete pulse

Behaviour:
- Reset (rst low): state IDLE, ROM pointer 0, delay counters 0, all outputs 0 except o_reset_val = 1.
  - Reset mid-operation aborts immediately; no pulse completes afterwards.
- ROM entry is 10 bits {type[1:0], payload[7:0]}:
  - 00 = command, DC = 0.
  - 01 = data, DC = 1.
  - 10 = delay of payload ms; payload 0 means skip, 0 ms.
  - 11 = END.
- Fixed script:
  - CMD 0x01, DLY 5
  - CMD 0x11, DLY 120
  - CMD 0x3A, DAT 0x55
  - CMD 0x36, DAT 0x48
  - CMD 0x29, END
  - Unused entries are END.
- States:
  - IDLE: i_start -> RST_LO; other inputs ignored.
  - RST_LO: o_reset_ena = 1, o_reset_val = 0 for exactly one cycle -> RST_LO_W.
  - RST_LO_W: wait i_reset_sent -> RST_HI. o_reset_val stays 0.
  - RST_HI: o_reset_ena = 1, o_reset_val = 1 for one cycle -> RST_HI_W.
  - RST_HI_W: wait i_reset_sent -> FETCH, pointer = 0.
  - FETCH (1 cycle): decode ROM[pointer].
    - cmd/data -> SEND.
    - delay with payload > 0 -> DELAY.
    - delay with payload 0 -> FETCH, pointer + 1.
    - END -> DONE.
    - If pointer reaches ROM_DEPTH, go to DONE; the pointer never wraps.
  - SEND: o_spi_start = 1 for one cycle with o_spi_dc/o_spi_data valid -> WAIT_TX.
  - WAIT_TX: hold dc/data; on i_spi_done -> FETCH, pointer + 1.
  - DELAY: ms counter loaded with payload; cycle counter counts CLK_PER_MS-1 down to 0.
    - Each rollover decrements the ms counter.
    - ms counter at 0 with cycle counter at 0 -> FETCH, pointer + 1.
    - Total dwell is payload*CLK_PER_MS cycles, ±1.
  - DONE: o_init_done = 1, o_busy = 0. Holds until rst.
- Ignored inputs:
  - i_reset_sent outside the RST_*_W states.
  - i_spi_done outside WAIT_TX.
  - i_start outside IDLE.
- Simultaneous i_start and rst low: reset wins.
- o_spi_start and o_reset_ena are never high in the same cycle.

Optional Feature:
- Macro INIT_RESTART_EN.
- Defined:
  - Adds input i_restart (1 bit).
  - A pulse in DONE clears o_init_done and goes to RST_LO, re-running the full sequence.
  - i_restart in any other state is ignored.
- Undefined: port absent; DONE is terminal until rst.

Test Plan:
- Sim setup: CLK_PER_MS = 4; reset-block model returns i_reset_sent 10 cycles after each o_reset_ena; SPI model returns i_spi_done 8 cycles after o_spi_start.
- Reset-pulse order: rst low 5 cycles, release, pulse i_start -> o_reset_ena pulses twice, first with val 0 then val 1; second pulse exactly 1 cycle after the first i_reset_sent plus the RST_HI cycle.
- Byte stream: full run -> SPI model captures (dc,data) = (0,01)(0,11)(0,3A)(1,55)(0,36)(1,48)(0,29). o_init_done rises, o_busy falls in the same cycle.
- Delay timing: gap from i_spi_done of 0x11 to o_spi_start of 0x3A = 120*4 cycles ±2. Gap after 0x01 = 20 cycles ±2.
- Spurious handshakes: i_spi_done pulsed during DELAY, i_reset_sent during SEND, i_start during WAIT_TX -> no state or byte change; byte list unchanged.
- Reset mid-operation: assert rst during the 120 ms DELAY -> all outputs at reset values next cycle. A fresh i_start replays the complete sequence from the reset pulse.
- INIT_RESTART_EN: i_restart in DONE -> o_init_done = 0 next cycle and the full sequence repeats. i_restart during WAIT_TX has no effect.
